// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives all datapath enables and selects (Moore outputs).
module multi_cycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             stall,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Terminal states retire the instruction on their way back to FETCH.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (opcode == OP_ADDI)             state_d = S_ADDI_EXEC;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        count_d = count_q + CNT_W'(1);
      end
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (!stall) begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  logic       pw_dec, pwc_dec, iod_dec, mr_dec, mw_dec, irw_dec;
  logic       m2r_dec, rd_dec, rw_dec, asa_dec;
  logic [1:0] asb_dec, aop_dec, psrc_dec;

  always_comb begin
    pw_dec   = 1'b0;
    pwc_dec  = 1'b0;
    iod_dec  = 1'b0;
    mr_dec   = 1'b0;
    mw_dec   = 1'b0;
    irw_dec  = 1'b0;
    m2r_dec  = 1'b0;
    rd_dec   = 1'b0;
    rw_dec   = 1'b0;
    asa_dec  = 1'b0;
    asb_dec  = 2'b00;
    aop_dec  = 2'b00;
    psrc_dec = 2'b00;
    case (state_q)
      S_FETCH: begin
        mr_dec  = 1'b1;
        irw_dec = 1'b1;
        pw_dec  = 1'b1;
        asb_dec = 2'b01;
      end
      S_DECODE:    asb_dec = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        asa_dec = 1'b1;
        asb_dec = 2'b10;
      end
      S_MEM_READ: begin
        mr_dec  = 1'b1;
        iod_dec = 1'b1;
      end
      S_MEM_WB: begin
        rw_dec  = 1'b1;
        m2r_dec = 1'b1;
      end
      S_MEM_WRITE: begin
        mw_dec  = 1'b1;
        iod_dec = 1'b1;
      end
      S_EXECUTE: begin
        asa_dec = 1'b1;
        aop_dec = 2'b10;
      end
      S_ALU_WB: begin
        rw_dec = 1'b1;
        rd_dec = 1'b1;
      end
      S_BRANCH: begin
        asa_dec  = 1'b1;
        aop_dec  = 2'b01;
        pwc_dec  = 1'b1;
        psrc_dec = 2'b01;
      end
      S_JUMP: begin
        pw_dec   = 1'b1;
        psrc_dec = 2'b10;
      end
      S_ADDI_WB:   rw_dec = 1'b1;
      default: ;
    endcase
  end

  // Stall suppresses only state-changing enables; reset silences everything.
  logic wr_ok, sel_ok;
  assign wr_ok  = ~stall & ~rst;
  assign sel_ok = ~rst;

  assign pc_write      = pw_dec  & wr_ok;
  assign pc_write_cond = pwc_dec & wr_ok;
  assign ir_write      = irw_dec & wr_ok;
  assign mem_write     = mw_dec  & wr_ok;
  assign reg_write     = rw_dec  & wr_ok;
  assign mem_read      = mr_dec  & sel_ok;
  assign i_or_d        = iod_dec & sel_ok;
  assign mem_to_reg    = m2r_dec & sel_ok;
  assign reg_dst       = rd_dec  & sel_ok;
  assign alu_src_a     = asa_dec & sel_ok;
  assign alu_src_b     = asb_dec  & {2{sel_ok}};
  assign alu_op        = aop_dec  & {2{sel_ok}};
  assign pc_source     = psrc_dec & {2{sel_ok}};

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction-level reference model (state paths per
// opcode, per-state control table) driven by directed and randomized instruction streams.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        stall = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          seq[$];
  int          idx;
  logic        cur_illegal;
  logic        done;
  logic        ill_exp;
  logic [31:0] cnt_exp;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] ctrl_of(input int s);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  function automatic logic [15:0] ctrl_obs();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // State path an instruction takes, by opcode.
  task automatic load_seq(input logic [5:0] op);
    cur_illegal = 1'b0;
    case (op)
      6'h23:   seq = '{0, 1, 2, 3, 4};
      6'h2B:   seq = '{0, 1, 2, 5};
      6'h00:   seq = '{0, 1, 6, 7};
      6'h08:   seq = '{0, 1, 10, 11};
      6'h04:   seq = '{0, 1, 8};
      6'h02:   seq = '{0, 1, 9};
      default: begin seq = '{0, 1}; cur_illegal = 1'b1; end
    endcase
    idx  = 0;
    done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_c;
    exp_c = ctrl_of(seq[idx]);
    if (stall) exp_c = exp_c & 16'h337F;
    vectors++;
    assert (ctrl_obs() === exp_c) else begin
      miscompares++;
      $error("FAIL %s ctrl st=%0d obs=%h exp=%h", tag, seq[idx], ctrl_obs(), exp_c);
    end
    vectors++;
    assert (state === 4'(seq[idx])) else begin
      miscompares++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state, seq[idx]);
    end
    vectors++;
    assert (illegal_op === ill_exp) else begin
      miscompares++;
      $error("FAIL %s illegal_op obs=%b exp=%b", tag, illegal_op, ill_exp);
    end
    vectors++;
    assert (instr_count === cnt_exp) else begin
      miscompares++;
      $error("FAIL %s instr_count obs=%0d exp=%0d", tag, instr_count, cnt_exp);
    end
  endtask

  // One clock: drive stall, check mid-cycle, advance the model at the edge.
  task automatic step(input logic st, input string tag);
    stall = st;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (!st) begin
      idx++;
      ill_exp = 1'b0;
      if (idx == seq.size()) begin
        if (cur_illegal) ill_exp = 1'b1;
        else cnt_exp = cnt_exp + 32'd1;
        idx  = 0;
        done = 1'b1;
      end
    end
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int stall_state, input int nstall,
                           input logic rand_stall, input string tag);
    int n;
    n = nstall;
    load_seq(op);
    opcode = op;
    while (!done) begin
      if (seq[idx] == stall_state && n > 0) begin
        step(1'b1, tag);
        n--;
      end else begin
        step(rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0, tag);
      end
    end
    $display("instr %s op=%h count=%0d", tag, op, cnt_exp);
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int pick;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    // Reset held two cycles: all control outputs silent.
    ill_exp = 1'b0;
    cnt_exp = 32'd0;
    load_seq(6'h00);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      assert (ctrl_obs() === 16'h0000) else begin
        miscompares++;
        $error("FAIL rst_ctrl obs=%h exp=0000", ctrl_obs());
      end
      vectors++;
      assert (state === 4'd0 && instr_count === 32'd0 && illegal_op === 1'b0) else begin
        miscompares++;
        $error("FAIL rst_regs state=%0d cnt=%0d ill=%b exp 0/0/0", state, instr_count, illegal_op);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released");

    // Directed instruction mix.
    run_instr(6'h23, -1, 0, 1'b0, "lw");
    run_instr(6'h00, -1, 0, 1'b0, "rtype");
    run_instr(6'h2B, -1, 0, 1'b0, "sw");
    run_instr(6'h04, -1, 0, 1'b0, "beq");
    run_instr(6'h02, -1, 0, 1'b0, "j");
    run_instr(6'h08, -1, 0, 1'b0, "addi");
    run_instr(6'h3F, -1, 0, 1'b0, "illegal");
    run_instr(6'h23, -1, 0, 1'b0, "lw_after_ill");
    run_instr(6'h2B, 5, 3, 1'b0, "sw_stall");
    run_instr(6'h3F, 0, 2, 1'b0, "ill_stall_fetch");
    run_instr(6'h00, 0, 1, 1'b0, "rtype_after_stall");

    // Reset during MEM_WB with stall: write aborted, no retire.
    load_seq(6'h23);
    opcode = 6'h23;
    repeat (4) step(1'b0, "lw_pre_rst");
    rst = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    vectors++;
    assert (ctrl_obs() === 16'h0000) else begin
      miscompares++;
      $error("FAIL rst_mid_ctrl obs=%h exp=0000", ctrl_obs());
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    assert (state === 4'd0 && instr_count === 32'd0 && reg_write === 1'b0) else begin
      miscompares++;
      $error("FAIL rst_mid_regs state=%0d cnt=%0d rw=%b exp 0/0/0", state, instr_count, reg_write);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stall = 1'b0;
    cnt_exp = 32'd0;
    ill_exp = 1'b0;
    $display("reset mid-instruction done");
    run_instr(6'h02, -1, 0, 1'b0, "j_after_rst");

    // Randomized instruction stream with random stalls.
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 6);
      if (pick < 6) op = legal_ops[pick];
      else begin
        op = 6'($urandom_range(0, 63));
        while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08)
          op = 6'($urandom_range(0, 63));
      end
      run_instr(op, -1, 0, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
